// File: rtl/stochastic_adc_cal_pkg.sv
// Shared types and helpers for the stochastic ADC offset calibration slice.
// Optional PFD self-test states are only reachable with STOCH_ADC_CAL_PFD_SELFTEST_EN.
package stochastic_adc_cal_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PFD_SET,
      ST_PFD_ACC,
      ST_SET_A,
      ST_ACC_A,
      ST_SET_B,
      ST_ACC_B,
      ST_UPDATE,
      ST_DONE
   } cal_state_t;

   // Midpoint of the default 5-bit V2T trim range
   localparam int TRIM_MID_DEFAULT = 16;

   // Sign-magnitude (sign=1 positive) to two's complement; caller sizes the result
   function automatic int sm2tc(input int mag, input logic sign);
      return sign ? mag : -mag;
   endfunction

endpackage

// File: rtl/adc_cal_accumulator.sv
// Signed sample accumulator: sums exactly 2**Navg enabled samples after a clear,
// then raises full and ignores further enables until the next clear.
module adc_cal_accumulator #(
   parameter int Nadc = 8,
   parameter int Navg = 8
) (
   input  logic               clk_adder,
   input  logic               rstb,
   input  logic               clr,
   input  logic               en,
   input  logic [Nadc:0]      sample,
   output logic [Nadc+Navg:0] sum,
   output logic               full
);

   logic [Nadc+Navg:0] sum_reg;
   logic [Navg:0]      cnt_reg;

   // Counter MSB marks that 2**Navg samples have been taken
   assign full = cnt_reg[Navg];
   assign sum  = sum_reg;

   always_ff @(posedge clk_adder or negedge rstb) begin
      if (!rstb) begin
         sum_reg <= '0;
         cnt_reg <= '0;
      end else if (clr) begin
         sum_reg <= '0;
         cnt_reg <= '0;
      end else if (en && !full) begin
         sum_reg <= sum_reg + {{Navg{sample[Nadc]}}, sample};
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/stochastic_adc_offset_cal.sv
// Chopped offset measurement and V2T trim stepping for one stochastic ADC slice.
// Define STOCH_ADC_CAL_PFD_SELFTEST_EN to add the PFD self-test pass and pfd_offset port.
module stochastic_adc_offset_cal
   import stochastic_adc_cal_pkg::*;
#(
   parameter int Nadc     = 8,
   parameter int Nctl_v2t = $clog2(TRIM_MID_DEFAULT) + 1,
   parameter int Navg     = 8,
   parameter int Nsettle  = 8,
   parameter int Niter    = 6
) (
   input  logic                clk_adder,
   input  logic                rstb,
   input  logic                start,
   input  logic                abort,
   input  logic [Nadc-1:0]     adder_out,
   input  logic                sign_out,
   input  logic [Nadc-1:0]     tol,
   input  logic [Niter-1:0]    max_iter,
   input  logic [Nctl_v2t-1:0] trim_p_init,
   input  logic [Nctl_v2t-1:0] trim_n_init,
   output logic [Nctl_v2t-1:0] ctl_v2t_p,
   output logic [Nctl_v2t-1:0] ctl_v2t_n,
   output logic                en_TDC_phase_reverse,
   output logic [1:0]          sel_PFD_in,
   output logic                busy,
   output logic                done,
   output logic                fail,
   output logic [Nadc:0]       offset_est
`ifdef STOCH_ADC_CAL_PFD_SELFTEST_EN
   ,
   output logic [Nadc:0]       pfd_offset
`endif
);

   localparam int SETTLE_W = $clog2(Nsettle + 1);
   localparam logic [Nctl_v2t-1:0] TRIM_MID = {1'b1, {(Nctl_v2t-1){1'b0}}};
   localparam logic [Nctl_v2t-1:0] TRIM_MAX = {Nctl_v2t{1'b1}};

   cal_state_t          state_reg, state_next;
   logic [SETTLE_W-1:0] settle_cnt_reg;
   logic [Niter-1:0]    iter_reg, iter_next;
   logic [Nctl_v2t-1:0] trim_p_reg, trim_p_next;
   logic [Nctl_v2t-1:0] trim_n_reg, trim_n_next;
   logic                done_reg, done_next;
   logic                fail_reg, fail_next;
   logic [Nadc:0]       est_reg, est_next;
   logic [Nadc:0]       s_reg;

   logic                settle_done;
   logic                acc_a_clr, acc_a_en, acc_a_full;
   logic                acc_b_clr, acc_b_en, acc_b_full;
   logic signed [Nadc+Navg:0]   acc_a_sum, acc_b_sum;
   logic signed [Nadc+Navg+1:0] sum_ab;
   logic signed [Nadc:0]        est_now;
   logic signed [Nadc+1:0]      est_ext, tol_pos, tol_neg;
   logic                        est_within, est_high;

   // Registered sign-magnitude to two's complement conversion of the ADC output
   always_ff @(posedge clk_adder or negedge rstb) begin
      if (!rstb) begin
         s_reg <= '0;
      end else begin
         s_reg <= (Nadc+1)'(sm2tc(int'(adder_out), sign_out));
      end
   end

   assign acc_a_clr = (state_reg == ST_SET_A) || (state_reg == ST_PFD_SET);
   assign acc_a_en  = (state_reg == ST_ACC_A) || (state_reg == ST_PFD_ACC);
   assign acc_b_clr = (state_reg == ST_SET_B);
   assign acc_b_en  = (state_reg == ST_ACC_B);

   adc_cal_accumulator #(.Nadc(Nadc), .Navg(Navg)) u_acc_a (
      .clk_adder (clk_adder),
      .rstb      (rstb),
      .clr       (acc_a_clr),
      .en        (acc_a_en),
      .sample    (s_reg),
      .sum       (acc_a_sum),
      .full      (acc_a_full)
   );

   adc_cal_accumulator #(.Nadc(Nadc), .Navg(Navg)) u_acc_b (
      .clk_adder (clk_adder),
      .rstb      (rstb),
      .clr       (acc_b_clr),
      .en        (acc_b_en),
      .sample    (s_reg),
      .sum       (acc_b_sum),
      .full      (acc_b_full)
   );

   // Average over both chop phases; the shift floors toward -inf
   assign sum_ab     = $signed({acc_a_sum[Nadc+Navg], acc_a_sum}) +
                       $signed({acc_b_sum[Nadc+Navg], acc_b_sum});
   assign est_now    = (Nadc+1)'(sum_ab >>> (Navg + 1));
   assign est_ext    = {est_now[Nadc], est_now};
   assign tol_pos    = $signed({2'b00, tol});
   assign tol_neg    = -tol_pos;
   assign est_within = (est_ext <= tol_pos) && (est_ext >= tol_neg);
   assign est_high   = (est_ext > tol_pos);

   assign settle_done = (settle_cnt_reg == SETTLE_W'(Nsettle - 1));

`ifdef STOCH_ADC_CAL_PFD_SELFTEST_EN
   logic [Nadc:0] pfd_reg, pfd_next;
   always_ff @(posedge clk_adder or negedge rstb) begin
      if (!rstb) begin
         pfd_reg <= '0;
      end else begin
         pfd_reg <= pfd_next;
      end
   end
   assign pfd_offset = pfd_reg;
   // Both PFD inputs share one clock for exactly the settle plus sample window
   assign sel_PFD_in = ((state_reg == ST_PFD_SET) ||
                        ((state_reg == ST_PFD_ACC) && !acc_a_full)) ? 2'b11 : 2'b00;
`else
   assign sel_PFD_in = 2'b00;
`endif

   always_ff @(posedge clk_adder or negedge rstb) begin
      if (!rstb) begin
         state_reg      <= ST_IDLE;
         settle_cnt_reg <= '0;
         iter_reg       <= '0;
         trim_p_reg     <= TRIM_MID;
         trim_n_reg     <= TRIM_MID;
         done_reg       <= 1'b0;
         fail_reg       <= 1'b0;
         est_reg        <= '0;
      end else begin
         state_reg <= state_next;
         if (state_next != state_reg) begin
            settle_cnt_reg <= '0;
         end else if (!settle_done) begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
         end
         iter_reg   <= iter_next;
         trim_p_reg <= trim_p_next;
         trim_n_reg <= trim_n_next;
         done_reg   <= done_next;
         fail_reg   <= fail_next;
         est_reg    <= est_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      iter_next   = iter_reg;
      trim_p_next = trim_p_reg;
      trim_n_next = trim_n_reg;
      done_next   = done_reg;
      fail_next   = fail_reg;
      est_next    = est_reg;
`ifdef STOCH_ADC_CAL_PFD_SELFTEST_EN
      pfd_next    = pfd_reg;
`endif
      if (abort) begin
         state_next = ST_IDLE;
         done_next  = 1'b0;
         fail_next  = 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  trim_p_next = trim_p_init;
                  trim_n_next = trim_n_init;
                  iter_next   = '0;
                  done_next   = 1'b0;
                  fail_next   = 1'b0;
`ifdef STOCH_ADC_CAL_PFD_SELFTEST_EN
                  state_next  = ST_PFD_SET;
`else
                  state_next  = ST_SET_A;
`endif
               end
            end
`ifdef STOCH_ADC_CAL_PFD_SELFTEST_EN
            ST_PFD_SET: if (settle_done) state_next = ST_PFD_ACC;
            ST_PFD_ACC: begin
               if (acc_a_full) begin
                  pfd_next   = (Nadc+1)'(acc_a_sum >>> Navg);
                  state_next = ST_SET_A;
               end
            end
`endif
            ST_SET_A: if (settle_done) state_next = ST_ACC_A;
            ST_ACC_A: if (acc_a_full)  state_next = ST_SET_B;
            ST_SET_B: if (settle_done) state_next = ST_ACC_B;
            ST_ACC_B: if (acc_b_full)  state_next = ST_UPDATE;
            ST_UPDATE: begin
               est_next = est_now;
               if (est_within) begin
                  state_next = ST_DONE;
                  done_next  = 1'b1;
                  fail_next  = 1'b0;
               end else if (iter_reg == max_iter) begin
                  state_next = ST_DONE;
                  done_next  = 1'b1;
                  fail_next  = 1'b1;
               end else if (est_high ? (trim_p_reg == '0 || trim_n_reg == TRIM_MAX)
                                     : (trim_p_reg == TRIM_MAX || trim_n_reg == '0)) begin
                  // A trim is pinned at its rail, so stepping cannot reduce the offset
                  state_next = ST_DONE;
                  done_next  = 1'b1;
                  fail_next  = 1'b1;
               end else begin
                  trim_p_next = est_high ? trim_p_reg - 1'b1 : trim_p_reg + 1'b1;
                  trim_n_next = est_high ? trim_n_reg + 1'b1 : trim_n_reg - 1'b1;
                  iter_next   = iter_reg + 1'b1;
                  state_next  = ST_SET_A;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   assign ctl_v2t_p            = trim_p_reg;
   assign ctl_v2t_n            = trim_n_reg;
   assign en_TDC_phase_reverse = (state_reg == ST_SET_B) || (state_reg == ST_ACC_B);
   assign busy                 = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
   assign done                 = done_reg;
   assign fail                 = fail_reg;
   assign offset_est           = est_reg;

endmodule

// File: tb/tb_stochastic_adc_offset_cal.sv
// Randomized and directed bench for stochastic_adc_offset_cal with a behavioural slice
// model; STOCH_ADC_CAL_PFD_SELFTEST_EN adds the PFD pass to latency and checks pfd_offset.
module tb_stochastic_adc_offset_cal;

   localparam int NADC    = 8;
   localparam int NCTL    = 5;
   localparam int NAVG    = 4;
   localparam int NSETTLE = 4;
   localparam int NITER   = 6;
   localparam int TMAX    = (1 << NCTL) - 1;
   localparam int LAT     = 2 * (NSETTLE + (1 << NAVG)) + 3;
`ifdef STOCH_ADC_CAL_PFD_SELFTEST_EN
   localparam int EXTRA   = NSETTLE + (1 << NAVG) + 1;
`else
   localparam int EXTRA   = 0;
`endif

   logic            clk_adder = 1'b0;
   logic            rstb;
   logic            start, abort;
   logic [NADC-1:0] adder_out;
   logic            sign_out;
   logic [NADC-1:0] tol;
   logic [NITER-1:0] max_iter;
   logic [NCTL-1:0] trim_p_init, trim_n_init;
   logic [NCTL-1:0] ctl_v2t_p, ctl_v2t_n;
   logic            en_TDC_phase_reverse;
   logic [1:0]      sel_PFD_in;
   logic            busy, done, fail;
   logic [NADC:0]   offset_est;
`ifdef STOCH_ADC_CAL_PFD_SELFTEST_EN
   logic [NADC:0]   pfd_offset;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int va, vb, p0, n0, pfd_val;

   always #5 clk_adder = ~clk_adder;

   stochastic_adc_offset_cal #(
      .Nadc(NADC), .Nctl_v2t(NCTL), .Navg(NAVG), .Nsettle(NSETTLE), .Niter(NITER)
   ) dut (
      .clk_adder            (clk_adder),
      .rstb                 (rstb),
      .start                (start),
      .abort                (abort),
      .adder_out            (adder_out),
      .sign_out             (sign_out),
      .tol                  (tol),
      .max_iter             (max_iter),
      .trim_p_init          (trim_p_init),
      .trim_n_init          (trim_n_init),
      .ctl_v2t_p            (ctl_v2t_p),
      .ctl_v2t_n            (ctl_v2t_n),
      .en_TDC_phase_reverse (en_TDC_phase_reverse),
      .sel_PFD_in           (sel_PFD_in),
      .busy                 (busy),
      .done                 (done),
      .fail                 (fail),
      .offset_est           (offset_est)
`ifdef STOCH_ADC_CAL_PFD_SELFTEST_EN
      ,
      .pfd_offset           (pfd_offset)
`endif
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Slice model: offset follows half the trim difference change; chopping selects A/B value
   task automatic drive_adc();
      int v;
      int d;
      d = ((int'(ctl_v2t_p) - int'(ctl_v2t_n)) - (p0 - n0)) / 2;
      v = (en_TDC_phase_reverse ? vb : va) + d;
      if (sel_PFD_in == 2'b11) v = pfd_val;
      if (v > 255) v = 255;
      if (v < -255) v = -255;
      sign_out  = (v >= 0);
      adder_out = NADC'((v >= 0) ? v : -v);
   endtask

   task automatic tick();
      @(posedge clk_adder);
      #1;
      drive_adc();
   endtask

   function automatic int floor_div(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   task automatic model(input int a_i, input int b_i, input int p_i, input int n_i,
                        input int t_i, input int m_i,
                        output int ep, output int en, output int ef,
                        output int eest, output int eupd);
      int p, n, it, d;
      p = p_i; n = n_i; it = 0; eupd = 0; ef = 0; eest = 0;
      for (int k = 0; k < 100; k++) begin
         d = ((p - n) - (p_i - n_i)) / 2;
         eest = floor_div(((a_i + d) + (b_i + d)) * (1 << NAVG), 1 << (NAVG + 1));
         eupd++;
         if (eest <= t_i && eest >= -t_i) begin ef = 0; break; end
         if (it == m_i) begin ef = 1; break; end
         if (eest > t_i) begin
            if (p == 0 || n == TMAX) begin ef = 1; break; end
            p--; n++;
         end else begin
            if (p == TMAX || n == 0) begin ef = 1; break; end
            p++; n--;
         end
         it++;
      end
      ep = p; en = n;
   endtask

   task automatic run_scenario(input int a, input int b, input int pi, input int ni,
                               input int t, input int m);
      int ep, en, ef, eest, eupd, cyc;
      va = a; vb = b; p0 = pi; n0 = ni;
      trim_p_init = NCTL'(pi);
      trim_n_init = NCTL'(ni);
      tol         = NADC'(t);
      max_iter    = NITER'(m);
      model(a, b, pi, ni, t, m, ep, en, ef, eest, eupd);
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 3000) begin
         tick();
         cyc++;
      end
      check("latency", cyc, EXTRA + eupd * LAT);
      check("done", int'(done), 1);
      check("fail", int'(fail), ef);
      check("trim_p", int'(ctl_v2t_p), ep);
      check("trim_n", int'(ctl_v2t_n), en);
      check("offset_est", int'($signed(offset_est)), eest);
      check("busy_done", int'(busy), 0);
`ifdef STOCH_ADC_CAL_PFD_SELFTEST_EN
      check("pfd_offset", int'($signed(pfd_offset)), pfd_val);
`endif
      $display("scenario a=%0d b=%0d p0=%0d n0=%0d tol=%0d max=%0d -> est=%0d p=%0d n=%0d fail=%0d cycles=%0d",
               a, b, pi, ni, t, m, int'($signed(offset_est)), ctl_v2t_p, ctl_v2t_n, fail, cyc);
   endtask

   initial begin
      rstb = 1'b0; start = 1'b0; abort = 1'b0;
      tol = NADC'(1); max_iter = NITER'(63);
      trim_p_init = NCTL'(16); trim_n_init = NCTL'(16);
      va = 0; vb = 0; p0 = 16; n0 = 16; pfd_val = -2;
      drive_adc();
      repeat (3) tick();
      check("rst_trim_p", int'(ctl_v2t_p), 16);
      check("rst_trim_n", int'(ctl_v2t_n), 16);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_fail", int'(fail), 0);
      check("rst_phase", int'(en_TDC_phase_reverse), 0);
      check("rst_sel_pfd", int'(sel_PFD_in), 0);
      check("rst_est", int'(offset_est), 0);
      rstb = 1'b1;
      tick();

      // Directed: convergence, chopped cancellation, trim rail, iteration limit
      run_scenario(3, 3, 16, 16, 1, 63);
      run_scenario(5, -5, 16, 16, 1, 63);
      run_scenario(10, 10, 0, 16, 1, 63);
      run_scenario(20, 20, 16, 16, 1, 2);

      for (int i = 0; i < 14; i++) begin
         pfd_val = int'($urandom_range(0, 40)) - 20;
         run_scenario(int'($urandom_range(0, 80)) - 40, int'($urandom_range(0, 80)) - 40,
                      int'($urandom_range(0, TMAX)), int'($urandom_range(0, TMAX)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 12)));
      end

      // Abort in ACC_B of the second pass; a start pulse while busy must be ignored
      pfd_val = -2;
      va = 3; vb = 3; p0 = 16; n0 = 16;
      trim_p_init = NCTL'(16); trim_n_init = NCTL'(16);
      tol = NADC'(1); max_iter = NITER'(63);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= EXTRA + LAT + 30; i++) begin
         start       = (i == 6);
         trim_p_init = (i == 6) ? NCTL'(3) : NCTL'(16);
         tick();
      end
      start = 1'b0;
      trim_p_init = NCTL'(16);
      check("pre_abort_phase", int'(en_TDC_phase_reverse), 1);
      check("pre_abort_busy", int'(busy), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_phase", int'(en_TDC_phase_reverse), 0);
      check("abort_sel_pfd", int'(sel_PFD_in), 0);
      check("abort_trim_p", int'(ctl_v2t_p), 15);
      check("abort_trim_n", int'(ctl_v2t_n), 17);
      tick();
      check("abort_idle_hold", int'(busy), 0);
      $display("abort in ACC_B -> busy=%0d p=%0d n=%0d", busy, ctl_v2t_p, ctl_v2t_n);

      // Asynchronous reset during SET_B of the second pass
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= EXTRA + LAT + 22; i++) tick();
      check("pre_rst_phase", int'(en_TDC_phase_reverse), 1);
      check("pre_rst_trim_p", int'(ctl_v2t_p), 15);
      #2;
      rstb = 1'b0;
      #1;
      check("midrst_trim_p", int'(ctl_v2t_p), 16);
      check("midrst_trim_n", int'(ctl_v2t_n), 16);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_fail", int'(fail), 0);
      check("midrst_phase", int'(en_TDC_phase_reverse), 0);
      check("midrst_est", int'(offset_est), 0);
      tick();
      rstb = 1'b1;
      tick();
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_trim_p", int'(ctl_v2t_p), 16);
      $display("reset in SET_B -> busy=%0d p=%0d n=%0d est=%0d", busy, ctl_v2t_p, ctl_v2t_n, offset_est);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
